multi_switch_debouncer: RTL

//  N-channel debouncer and press/release detector for the alarm-clock push buttons.

---
 rtl/multi_switch_debouncer_pkg.sv | 28 ++
 rtl/multi_switch_debouncer_if.sv | 34 +++
 rtl/multi_switch_debouncer_channel.sv | 189 ++++++++++++++++++
 rtl/multi_switch_debouncer.sv | 56 +++++
 4 files changed

// File: rtl/multi_switch_debouncer_pkg.sv
// Package dac_debounce_pkg
// Purpose : shared definitions for the push-button debouncer family.
//           Holds the per-channel FSM state encoding and the default sample
//           counts used by every button consumer.
// Config  : none here; the long-press feature is selected with LONG_PRESS_EN
//           in the channel and top files.
package dac_debounce_pkg;

    localparam int DEB_STATE_W = 2;

    typedef enum logic [DEB_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2,
        ST_REL   = 2'd3
    } deb_state_t;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_PRESS_CNT   = 4;
    localparam int DEF_RELEASE_CNT = 4;
    localparam int DEF_LONG_CNT    = 16;

    // Width needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/multi_switch_debouncer_if.sv
// Interface multi_switch_debouncer_if
// Purpose : groups the switch inputs and the per-channel debouncer outputs.
// Signals : switch_in   raw switch levels, 1 = pressed
//           sw_level    debounced level per channel
//           click_pulse 1-clk pulse on completed press+release
//           long_pulse  1-clk pulse on long press (LONG_PRESS_EN builds only)
//           state_dbg   packed per-channel FSM state, 2 bits per channel
// Modports: slave  = debouncer side, master = switch/consumer side.
// Config  : LONG_PRESS_EN affects only the debouncer, not this interface.
interface multi_switch_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   switch_in;
    logic [N_CH-1:0]   sw_level;
    logic [N_CH-1:0]   click_pulse;
    logic [N_CH-1:0]   long_pulse;
    logic [2*N_CH-1:0] state_dbg;

    modport slave (
        input  switch_in,
        output sw_level,
        output click_pulse,
        output long_pulse,
        output state_dbg
    );

    modport master (
        output switch_in,
        input  sw_level,
        input  click_pulse,
        input  long_pulse,
        input  state_dbg
    );
endinterface

// File: rtl/multi_switch_debouncer_channel.sv
// Module debounce_channel
// Purpose : one switch channel: 2-flop synchroniser followed by the
//           IDLE/PRESS/HELD/REL debounce FSM with registered outputs.
// Ports   : clk, reset (async, active-high), tick (sample strobe),
//           switch_in (raw), sw_level, click_pulse, long_pulse, state_dbg.
// Config  : LONG_PRESS_EN adds a hold counter and long-press flag; without
//           it long_pulse is tied to 0.
module debounce_channel
    import dac_debounce_pkg::*;
#(
    parameter int PRESS_CNT   = DEF_PRESS_CNT,
    parameter int RELEASE_CNT = DEF_RELEASE_CNT,
    parameter int LONG_CNT    = DEF_LONG_CNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       switch_in,
    output logic       sw_level,
    output logic       click_pulse,
    output logic       long_pulse,
    output deb_state_t state_dbg
);

    localparam int CNT_W = cnt_width((PRESS_CNT > RELEASE_CNT) ? PRESS_CNT : RELEASE_CNT);

    if (PRESS_CNT < 1)        $error("PRESS_CNT must be >= 1");
    if (RELEASE_CNT < 1)      $error("RELEASE_CNT must be >= 1");
    if (LONG_CNT <= PRESS_CNT) $error("LONG_CNT must exceed PRESS_CNT");

    logic             sync1_q, sync2_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             s;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = cnt_width(LONG_CNT);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              flag_q, flag_d;
`endif

    assign s       = sync2_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        click_d = 1'b0;           // pulses self-clear every clk
        long_d  = 1'b0;
`ifdef LONG_PRESS_EN
        hold_d  = hold_q;
        flag_d  = flag_q;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        if (PRESS_CNT == 1) begin
                            state_d = ST_HELD;
                            level_d = 1'b1;
                            cnt_d   = '0;
`ifdef LONG_PRESS_EN
                            hold_d  = '0;
                            flag_d  = 1'b0;
`endif
                        end else begin
                            state_d = ST_PRESS;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS: begin
                    if (!s) begin
                        // press bounce: abandon silently
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(PRESS_CNT)) begin
                        state_d = ST_HELD;
                        level_d = 1'b1;
                        cnt_d   = '0;
`ifdef LONG_PRESS_EN
                        hold_d  = '0;
                        flag_d  = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        if (RELEASE_CNT == 1) begin
                            state_d = ST_IDLE;
                            level_d = 1'b0;
                            cnt_d   = '0;
`ifdef LONG_PRESS_EN
                            click_d = !flag_q;
                            hold_d  = '0;
                            flag_d  = 1'b0;
`else
                            click_d = 1'b1;
`endif
                        end else begin
                            state_d = ST_REL;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
`ifdef LONG_PRESS_EN
                        // hold counter saturates; the pulse fires once on arrival
                        if (hold_q < HOLD_W'(LONG_CNT)) begin
                            hold_d = hold_q + HOLD_W'(1);
                            if (hold_q + HOLD_W'(1) == HOLD_W'(LONG_CNT)) begin
                                long_d = 1'b1;
                                flag_d = 1'b1;
                            end
                        end
`endif
                    end
                end
                ST_REL: begin
                    if (s) begin
                        // release bounce: keep the press, hold count survives
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(RELEASE_CNT)) begin
                        state_d = ST_IDLE;
                        level_d = 1'b0;
                        cnt_d   = '0;
`ifdef LONG_PRESS_EN
                        click_d = !flag_q;
                        hold_d  = '0;
                        flag_d  = 1'b0;
`else
                        click_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            click_q <= 1'b0;
            long_q  <= 1'b0;
`ifdef LONG_PRESS_EN
            hold_q  <= '0;
            flag_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= switch_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            click_q <= click_d;
            long_q  <= long_d;
`ifdef LONG_PRESS_EN
            hold_q  <= hold_d;
            flag_q  <= flag_d;
`endif
        end
    end

    assign sw_level    = level_q;
    assign click_pulse = click_q;
`ifdef LONG_PRESS_EN
    assign long_pulse  = long_q;
`else
    // long_d is never raised in this build, so this flop stays at 0
    assign long_pulse  = long_q;
`endif
    assign state_dbg   = state_q;

endmodule

// File: rtl/multi_switch_debouncer.sv
// Module multi_switch_debouncer
// Purpose : N_CH independent push-button debouncers with press/release
//           click detection, all sampled on a shared tick strobe.
// Ports   : clk    system clock
//           reset  asynchronous active-high reset
//           tick   one-clk sample strobe
//           bus    multi_switch_debouncer_if.slave (switch_in, sw_level,
//                  click_pulse, long_pulse, state_dbg)
// Config  : LONG_PRESS_EN enables long-press detection after LONG_CNT held
//           ticks; undefined leaves long_pulse at 0.
module multi_switch_debouncer
    import dac_debounce_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int PRESS_CNT   = DEF_PRESS_CNT,
    parameter int RELEASE_CNT = DEF_RELEASE_CNT,
    parameter int LONG_CNT    = DEF_LONG_CNT
) (
    input logic                      clk,
    input logic                      reset,
    input logic                      tick,
    multi_switch_debouncer_if.slave  bus
);

    logic [N_CH-1:0]   level_w;
    logic [N_CH-1:0]   click_w;
    logic [N_CH-1:0]   long_w;
    logic [2*N_CH-1:0] state_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        deb_state_t st;

        debounce_channel #(
            .PRESS_CNT  (PRESS_CNT),
            .RELEASE_CNT(RELEASE_CNT),
            .LONG_CNT   (LONG_CNT)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .switch_in  (bus.switch_in[i]),
            .sw_level   (level_w[i]),
            .click_pulse(click_w[i]),
            .long_pulse (long_w[i]),
            .state_dbg  (st)
        );

        assign state_w[2*i +: 2] = st;
    end

    assign bus.sw_level    = level_w;
    assign bus.click_pulse = click_w;
    assign bus.long_pulse  = long_w;
    assign bus.state_dbg   = state_w;

endmodule
